// File: rtl/fifo_rd_unpacker_if.sv
// FIFO read-port and downstream byte-sink signals of the read-side unpacker.
// master = unpacker side, slave = FIFO memory / byte sink side.
interface fifo_rd_unpacker_if #(
  parameter int DATA_WIDTH = 8
);
  logic                      rempty;
  logic [2*DATA_WIDTH-1:0]   rd_data;
  logic                      rd_data_valid;
  logic                      rinc;
  logic [DATA_WIDTH-1:0]     out_data;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    input  rempty, rd_data, rd_data_valid, out_ready,
    output rinc, out_data, out_valid
  );

  modport slave (
    output rempty, rd_data, rd_data_valid, out_ready,
    input  rinc, out_data, out_valid
  );
endinterface

// File: rtl/fifo_rd_unpacker.sv
// Read-domain FIFO consumer: fetches 2-byte words one at a time and streams them
// to a byte sink low byte first, with a delivered-byte counter and sticky error flags.
module fifo_rd_unpacker #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 en,
  fifo_rd_unpacker_if.master   bus,
  output logic [CNT_WIDTH-1:0] byte_cnt,
  output logic [1:0]           err,
  output logic [1:0]           state_dbg
);

  // Sink handshake: a byte transfers on any cycle with out_valid && out_ready;
  // once out_valid rises it stays high with out_data stable until that transfer.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_LO   = 2'd2,
    ST_HI   = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [2*DATA_WIDTH-1:0] hold;
  logic                    can_read;
  logic                    load;
  logic                    miss;
  logic                    rinc;
  logic                    out_valid;
  logic [DATA_WIDTH-1:0]   out_data;

  // rrst_n is folded in so rinc is forced low for the whole reset, not just after the edge.
  assign can_read = rrst_n && en && !bus.rempty;

  always_comb begin
    state_nxt = state;
    rinc      = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    load      = 1'b0;
    miss      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (can_read) begin
          rinc      = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.rd_data_valid) begin
          load      = 1'b1;
          state_nxt = ST_LO;
        end else begin
          miss      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_LO: begin
        out_valid = 1'b1;
        out_data  = hold[DATA_WIDTH-1:0];
        if (bus.out_ready) state_nxt = ST_HI;
      end
      ST_HI: begin
        out_valid = 1'b1;
        out_data  = hold[2*DATA_WIDTH-1:DATA_WIDTH];
        if (bus.out_ready) begin
          if (can_read) begin
            rinc      = 1'b1;
            state_nxt = ST_WAIT;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state    <= ST_IDLE;
      hold     <= '0;
      byte_cnt <= '0;
      err      <= 2'b00;
    end else begin
      state <= state_nxt;
      if (load) hold <= bus.rd_data;
      if (out_valid && bus.out_ready) byte_cnt <= byte_cnt + 1'b1;
      if (miss) err[0] <= 1'b1;
      // A strobe outside WAIT has no read behind it; its data is dropped.
      if (bus.rd_data_valid && (state != ST_WAIT)) err[1] <= 1'b1;
    end
  end

  assign bus.rinc      = rinc;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign state_dbg     = state;

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Directed bench for fifo_rd_unpacker: FIFO memory model, byte scoreboard and
// protocol monitor, plus a narrow-counter instance to observe byte_cnt wrap.
module tb_fifo_rd_unpacker;
  localparam int DW = 8;

  logic        rclk;
  logic        rrst_n;
  logic        en;
  logic [15:0] byte_cnt;
  logic [1:0]  err;
  logic [1:0]  state_dbg;
  logic [3:0]  byte_cnt_w;
  logic [1:0]  err_w;
  logic [1:0]  state_dbg_w;

  fifo_rd_unpacker_if #(.DATA_WIDTH(DW)) bif ();
  fifo_rd_unpacker_if #(.DATA_WIDTH(DW)) wif ();

  fifo_rd_unpacker #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .en(en), .bus(bif.master),
    .byte_cnt(byte_cnt), .err(err), .state_dbg(state_dbg)
  );

  // Same stimulus, 4-bit counter, so wrap-around is reachable in a short run.
  assign wif.rempty        = bif.rempty;
  assign wif.rd_data       = bif.rd_data;
  assign wif.rd_data_valid = bif.rd_data_valid;
  assign wif.out_ready     = bif.out_ready;

  fifo_rd_unpacker #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_w (
    .rclk(rclk), .rrst_n(rrst_n), .en(en), .bus(wif.master),
    .byte_cnt(byte_cnt_w), .err(err_w), .state_dbg(state_dbg_w)
  );

  // ---------------- clock ----------------
  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  // ---------------- bookkeeping ----------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int          rinc_times[$];
  int          hs_times[$];
  int          exp_cnt = 0;
  int          cyc = 0;
  int          last_rinc = -100;
  bit          took = 0;
  bit          withhold = 0;
  bit          inject = 0;
  bit          stall = 0;
  logic [DW-1:0] stall_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO memory model ----------------
  initial begin
    bif.rempty        = 1'b1;
    bif.rd_data       = '0;
    bif.rd_data_valid = 1'b0;
  end

  always @(posedge rclk) begin
    #1;
    bif.rd_data_valid = 1'b0;
    if (took) begin
      took = 0;
      if (fifo_q.size() > 0) begin
        bif.rd_data       = fifo_q.pop_front();
        bif.rd_data_valid = !withhold;
      end
      withhold = 0;
    end
    if (inject) begin
      bif.rd_data       = 16'hDEAD;
      bif.rd_data_valid = 1'b1;
      inject = 0;
    end
    bif.rempty = (fifo_q.size() == 0);
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge rclk) begin
    if (!rrst_n) begin
      exp_cnt   = 0;
      stall     = 0;
      took      = 0;
      last_rinc = -100;
    end else begin
      chk("byte_cnt", {16'h0, byte_cnt}, exp_cnt & 32'hFFFF);
      chk("byte_cnt_w", {28'h0, byte_cnt_w}, exp_cnt & 32'hF);
      if (bif.out_valid) begin
        if (stall) chk("data_stable", {24'h0, bif.out_data}, {24'h0, stall_data});
        if (bif.out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none", bif.out_data);
          end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (bif.out_data !== e) begin
              errors++;
              $display("FAIL byte_order: got %0h expected %0h", bif.out_data, e);
            end
          end
          exp_cnt++;
          hs_times.push_back(cyc);
          stall = 0;
        end else begin
          stall      = 1;
          stall_data = bif.out_data;
        end
      end else begin
        chk("idle_data_zero", {24'h0, bif.out_data}, 32'h0);
        if (stall) chk("valid_dropped", 32'h0, 32'h1);
        stall = 0;
      end
      if (bif.rinc) begin
        chk("rinc_not_empty", {31'h0, bif.rempty}, 32'h0);
        chk("rinc_spacing_ge3", (cyc - last_rinc >= 3) ? 32'h1 : 32'h0, 32'h1);
        rinc_times.push_back(cyc);
        last_rinc = cyc;
      end
      took = bif.rinc;
      cyc++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic push_word(input logic [15:0] w, input bit expect_out);
    fifo_q.push_back(w);
    if (expect_out) begin
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bif.out_valid && n < 50) begin
      step(1);
      n++;
    end
    chk(name, {31'h0, bif.out_valid}, 32'h1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < 400) begin
      step(1);
      n++;
    end
    chk(name, exp_q.size() + fifo_q.size(), 32'h0);
    step(3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rrst_n        = 1'b0;
    en            = 1'b0;
    bif.out_ready = 1'b0;
    step(2);
    chk("rst_rinc", {31'h0, bif.rinc}, 32'h0);
    chk("rst_out_valid", {31'h0, bif.out_valid}, 32'h0);
    chk("rst_out_data", {24'h0, bif.out_data}, 32'h0);
    chk("rst_byte_cnt", {16'h0, byte_cnt}, 32'h0);
    chk("rst_err", {30'h0, err}, 32'h0);
    rrst_n = 1'b1;
    step(2);

    // single word B2A1: A1 two cycles after rinc, B2 the cycle after
    en = 1'b1;
    bif.out_ready = 1'b1;
    rinc_times.delete();
    hs_times.delete();
    push_word(16'hB2A1, 1'b1);
    wait_drain("t1_drain");
    step(3);
    chk("t1_rinc_count", rinc_times.size(), 32'd1);
    chk("t1_lo_latency", hs_times[0] - rinc_times[0], 32'd2);
    chk("t1_hi_next", hs_times[1] - hs_times[0], 32'd1);
    chk("t1_idle_valid", {31'h0, bif.out_valid}, 32'h0);
    chk("t1_byte_cnt", {16'h0, byte_cnt}, 32'd2);
    chk("t1_err", {30'h0, err}, 32'h0);

    // four words streamed: rinc exactly every third cycle
    rinc_times.delete();
    push_word(16'h2201, 1'b1);
    push_word(16'h4403, 1'b1);
    push_word(16'h6605, 1'b1);
    push_word(16'h8807, 1'b1);
    wait_drain("t2_drain");
    chk("t2_rinc_count", rinc_times.size(), 32'd4);
    for (int i = 1; i < 4; i++)
      chk("t2_rinc_gap", rinc_times[i] - rinc_times[i-1], 32'd3);
    chk("t2_byte_cnt", {16'h0, byte_cnt}, 32'd10);

    // back-pressure in LO with another word waiting
    bif.out_ready = 1'b0;
    push_word(16'hC3D4, 1'b1);
    push_word(16'hE5F6, 1'b1);
    wait_valid("t3_wait_lo");
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_valid", {31'h0, bif.out_valid}, 32'h1);
      chk("t3_stall_data", {24'h0, bif.out_data}, 32'hD4);
      chk("t3_stall_no_rinc", {31'h0, bif.rinc}, 32'h0);
      step(1);
    end
    bif.out_ready = 1'b1;
    wait_drain("t3_drain");
    chk("t3_byte_cnt", {16'h0, byte_cnt}, 32'd14);

    // missing rd_data_valid, then a stray strobe in IDLE
    withhold = 1;
    push_word(16'h5A5A, 1'b0);
    wait_drain("t4_drain");
    step(2);
    chk("t4_err_miss", {30'h0, err}, 32'h1);
    chk("t4_no_valid", {31'h0, bif.out_valid}, 32'h0);
    chk("t4_byte_cnt", {16'h0, byte_cnt}, 32'd14);
    inject = 1;
    step(4);
    chk("t4_err_unexp", {30'h0, err}, 32'h3);

    // en dropped during LO: word completes, next one waits for en
    bif.out_ready = 1'b0;
    push_word(16'h1357, 1'b1);
    push_word(16'h2468, 1'b1);
    wait_valid("t5_wait_lo");
    en = 1'b0;
    bif.out_ready = 1'b1;
    step(8);
    chk("t5_pending_bytes", exp_q.size(), 32'd2);
    chk("t5_fifo_left", fifo_q.size(), 32'd1);
    chk("t5_parked_valid", {31'h0, bif.out_valid}, 32'h0);
    chk("t5_parked_rinc", {31'h0, bif.rinc}, 32'h0);
    en = 1'b1;
    wait_drain("t5_drain");
    chk("t5_byte_cnt", {16'h0, byte_cnt}, 32'd18);

    // reset while HI is stalled; remaining high byte is discarded
    bif.out_ready = 1'b0;
    push_word(16'h9ABC, 1'b1);
    wait_valid("t6_wait_lo");
    bif.out_ready = 1'b1;
    step(1);
    bif.out_ready = 1'b0;
    chk("t6_hi_data", {24'h0, bif.out_data}, 32'h9A);
    #2;
    rrst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'h0, bif.out_valid}, 32'h0);
    chk("t6_rst_data", {24'h0, bif.out_data}, 32'h0);
    chk("t6_rst_byte_cnt", {16'h0, byte_cnt}, 32'h0);
    chk("t6_rst_err", {30'h0, err}, 32'h0);
    exp_q.delete();
    push_word(16'h0F1E, 1'b1);
    step(2);
    chk("t6_rst_rinc_forced", {31'h0, bif.rinc}, 32'h0);
    rrst_n = 1'b1;
    bif.out_ready = 1'b1;
    wait_drain("t6_drain");
    chk("t6_byte_cnt", {16'h0, byte_cnt}, 32'd2);

    // 7 more words: 16 bytes since reset, narrow counter wraps to 0
    push_word(16'h1100, 1'b1);
    push_word(16'h3322, 1'b1);
    push_word(16'h5544, 1'b1);
    push_word(16'h7766, 1'b1);
    push_word(16'h9988, 1'b1);
    push_word(16'hBBAA, 1'b1);
    push_word(16'hDDCC, 1'b1);
    wait_drain("t7_drain");
    chk("t7_wrap_w", {28'h0, byte_cnt_w}, 32'h0);
    chk("t7_byte_cnt", {16'h0, byte_cnt}, 32'd16);
    chk("t7_err", {30'h0, err}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_rd_unpacker.md
# fifo_rd_unpacker

Read-side consumer for the async FIFO memory, running entirely in the read clock domain. It issues single-cycle `rinc` pulses while the FIFO is non-empty and captures each registered 2-byte `rd_data` word when `rd_data_valid` returns. It then serialises the word to a downstream byte sink over a valid/ready handshake, low byte first. It also keeps a running byte count and sticky protocol-error flags for the read-side scoreboard.

## Interface
- `DATA_WIDTH`, 8, byte width; `rd_data` is 2*DATA_WIDTH.
- `CNT_WIDTH`, 16, width of delivered-byte counter.
- `rclk`  in  1  read clock; all logic on rising edge.
- `rrst_n`  in  1  reset, asynchronous assert, active-low.
- `en`  in  1  permits new FIFO reads; does not abort a word in progress.
- `rempty`  in  1  FIFO empty flag, read domain.
- `rd_data`  in  2*DATA_WIDTH  memory output; `[DATA_WIDTH-1:0]` is the older byte.
- `rd_data_valid`  in  1  memory strobe, high one cycle after an accepted `rinc`.
- `rinc`  out  1  read request to the FIFO, one cycle per word.
- `out_data`  out  DATA_WIDTH  byte to sink.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  sink accepts when `out_valid && out_ready`.
- `byte_cnt`  out  CNT_WIDTH  bytes accepted by sink since reset; wraps modulo 2^CNT_WIDTH.
- `err`  out  2  sticky: bit0 = missing `rd_data_valid`; bit1 = unexpected `rd_data_valid`.

## Operation
- FSM states: IDLE, WAIT, LO, HI. Reset state is IDLE.
- IDLE:
  - `rinc = en && !rempty`, driven combinationally from state and inputs.
  - When `rinc` is 1, go to WAIT; otherwise stay.
- WAIT:
  - If `rd_data_valid`, load `hold <= rd_data` and go to LO.
  - Otherwise set `err[0]` and go to IDLE; no byte is emitted.
- LO:
  - `out_valid = 1`, `out_data = hold[DATA_WIDTH-1:0]`.
  - On `out_ready`, go to HI; otherwise hold, with `out_data` stable.
- HI:
  - `out_valid = 1`, `out_data = hold[2*DATA_WIDTH-1:DATA_WIDTH]`.
  - On `out_ready`: if `en && !rempty`, assert `rinc` this cycle and go to WAIT; otherwise go to IDLE.
  - Without `out_ready`, hold.
- `rinc` is asserted only in IDLE or HI-with-handshake, and never in WAIT or LO, so at most one read is outstanding.
- `out_valid` is high in LO and HI only. Once high, it stays high with stable data until accepted.
- `out_data` is a mux of registered `hold` by state, with no combinational path from `rd_data`. It reads 0 in IDLE and WAIT.
- `byte_cnt` increments by 1 on every `out_valid && out_ready` cycle.
- `err[1]` is set when `rd_data_valid = 1` in any state other than WAIT; the data is ignored.
- Both `err` bits clear only on reset.
- `en` deasserted mid-word: LO/HI complete normally, then the FSM parks in IDLE.
- `rempty` rising in the same cycle as a HI handshake blocks `rinc`; the FSM goes to IDLE.
- Reset mid-operation: state returns to IDLE, and `hold`, `byte_cnt` and `err` clear. The partially sent word is discarded.

## Timing
- Reset values: `rinc = 0` (forced while `rrst_n` low), `out_valid = 0`, `out_data = 0`, `byte_cnt = 0`, `err = 2'b00`.
- Read latency, from `rinc` cycle N:
  - `rd_data_valid` in N+1 (WAIT).
  - Low byte is valid from N+2 (LO).
  - High byte is valid from N+3 at the earliest.
- Sustained throughput with `out_ready = 1` and a non-empty FIFO: 2 bytes per 3 cycles. The repeating cycle is `rinc` (HI) → WAIT → LO → HI.
- `rinc` never stays high for two consecutive cycles.
- `byte_cnt` updates the cycle after the handshake.
- `err` is set the cycle after the offending condition.

## Test plan
- FIFO preloaded with word `rd_data = 16'hB2A1`, `en = 1`, `out_ready = 1` → one `rinc` pulse. Then `out_data` is `8'hA1` and next cycle `8'hB2`, then `rempty = 1` keeps the FSM in IDLE. Final `byte_cnt = 2`, `err = 0`.
- Four words queued, `out_ready = 1` → `rinc` every 3rd cycle and 8 bytes delivered in order, low before high per word. `byte_cnt = 8`.
- Back-pressure: `out_ready = 0` for 5 cycles during LO → `out_valid` stays 1 and `out_data` is unchanged. No `rinc` occurs while stalled. Release produces normal completion.
- Fault injection:
  - `rd_data_valid` withheld after `rinc` → `err = 2'b01`, FSM returns to IDLE, no `out_valid`.
  - `rd_data_valid` pulsed in IDLE → `err[1] = 1`.
- `en` dropped during LO with the FIFO non-empty → current word completes (2 bytes), then no further `rinc`. Re-asserting `en` resumes reads.
- `rrst_n` asserted during HI → all outputs go to reset values immediately (asynchronously). After release, the next word is fetched from IDLE. `byte_cnt` preset near `2^16-1` via traffic wraps to 0.
